vdp_mac_seq: RTL
================

# vdp_mac_seq

Sequencing controller for the vector-dot-product MAC datapath. It accepts a stream of signed operand pairs over a valid/ready handshake and accumulates exactly K products per vector. It presents each finished dot product on a valid/ready result port, then clears for the next vector. It sits between the operand source (garbler/evaluator input feeders) and the downstream result consumer, and owns the accumulator clear/enable sequencing.

## Interface
- N, 8: operand bit-width (signed).
- K, 3: vector dimension, K ≥ 1; products accumulated per result.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  controller can accept an operand pair.
- g_input  in  N  signed garbler operand.
- e_input  in  N  signed evaluator operand.
- abort  in  1  synchronous discard of the current vector.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- o  out  2N+K-1  signed dot product.
- elem_idx  out  max(1,$clog2(K))  index of the next element to be accepted (0..K-1).

## Operation
- Arithmetic:
  - product = g_input × e_input, signed, 2N bits, sign-extended to 2N+K-1 bits.
  - The accumulator is 2N+K-1 bits signed.
  - |sum| ≤ K·2^(2N-2) < 2^(2N+K-2), so no overflow is possible. No saturation logic.
- FSM with two states: ACC and DONE.
- ACC:
  - in_ready=1, out_valid=0.
  - Handshake (in_valid & in_ready) adds the product to acc and increments elem_idx.
  - On the handshake with elem_idx==K-1: o ← acc+product, acc ← 0, elem_idx ← 0, go to DONE.
  - Cycles with in_valid=0 are bubbles; state holds.
- DONE:
  - in_ready=0, out_valid=1, o held stable.
  - When out_ready=1: out_valid drops next cycle and the FSM returns to ACC.
- abort=1, any state:
  - Next cycle: ACC, acc=0, elem_idx=0, out_valid=0.
  - An operand handshake in the same cycle is discarded.
  - A result in DONE is dropped even if out_ready=1 that cycle.
  - in_ready is not gated by abort.
- K=1: every accepted pair goes straight to DONE.
- Reset (rst=0, asynchronous, any time including mid-vector):
  - State ACC, acc=0, elem_idx=0, o=0, out_valid=0, in_ready=0 while rst is asserted.
  - in_ready=1 from the first clock edge after release.

## Timing
- Latency: out_valid rises on the edge that completes the K-th handshake, i.e. visible the cycle after that handshake.
- Throughput:
  - K+1 cycles per vector with continuous in_valid and out_ready held high.
  - The DONE cycle is a mandatory one-cycle bubble on the input.
- o changes only on the K-th handshake edge and on reset. It is stable for the whole time out_valid=1.
- in_ready and out_valid are registered-state decodes; there are no combinational paths from in_valid or out_ready.
- in_ready is never 1 while out_valid is 1.

## Test plan
- Basic, N=8, K=3:
  - Stimulus: pairs (1,4), (2,5), (3,6) on back-to-back cycles, out_ready=1.
  - Required: out_valid=1 the cycle after the 3rd handshake with o=32. elem_idx runs 0,1,2,0.
  - Required: in_ready returns 1 two cycles after the 3rd handshake.
- Signed extremes:
  - Stimulus: three pairs (-128,-128).
  - Required: o=49152, no wrap.
  - Stimulus: then (-128,127) ×3.
  - Required: o=-48768.
- Bubbles and backpressure:
  - Stimulus: in_valid toggles 1,0,1,0,1 with the pairs from the basic case; out_ready=0 for 5 cycles, then 1.
  - Required: o=32 held for those 5 cycles with out_valid=1 and in_ready=0.
  - Required: accept resumes the cycle after out_ready.
- Abort:
  - Stimulus: after 2 handshakes, abort=1 coincident with a third handshake.
  - Required: the third pair is discarded and elem_idx=0.
  - Stimulus: then (1,1) ×3.
  - Required: o=3.
  - Stimulus: abort asserted in DONE with out_ready=1.
  - Required: out_valid drops and no result is accepted.
- Reset mid-vector:
  - Stimulus: rst=0 asynchronously (between edges) after 1 handshake.
  - Required: out_valid=0, in_ready=0, o=0 immediately.
  - Stimulus: after release, (2,3) ×3.
  - Required: o=18.
- K=1 (parameter override):
  - Stimulus: each pair (-5,7).
  - Required: o=-35 one cycle later, at 2 cycles per result.

Source files
------------

// File: rtl/vdp_mac_seq.sv
// vdp_mac_seq: sequences a K-element signed dot product over a valid/ready
// operand stream. It presents each result on a valid/ready port, then clears
// the accumulator for the next vector.
module vdp_mac_seq #(
    parameter int unsigned N = 8,
    parameter int unsigned K = 3,
    localparam int unsigned OW = 2*N + K - 1,
    localparam int unsigned IW = (K > 1) ? $clog2(K) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [N-1:0]  g_input,
    input  logic signed [N-1:0]  e_input,
    input  logic                 abort,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] o,
    output logic [IW-1:0]        elem_idx
);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic signed [OW-1:0] acc_q;
    logic signed [OW-1:0] acc_d;
    logic signed [OW-1:0] o_d;
    logic [IW-1:0]        idx_d;
    logic                 in_ready_d;
    logic                 out_valid_d;

    logic signed [2*N-1:0] prod;
    logic signed [OW-1:0]  prod_ext;
    logic signed [OW-1:0]  sum;
    logic                  hs;
    logic                  last;

    // Signed product, sign-extended to accumulator width; the sum cannot overflow.
    assign prod     = g_input * e_input;
    assign prod_ext = OW'(prod);
    assign sum      = acc_q + prod_ext;
    // in_ready is only ever high in ACC, so it qualifies the handshake alone.
    assign hs       = in_valid & in_ready;
    assign last     = (elem_idx == IW'(K - 1));

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        o_d         = o;
        idx_d       = elem_idx;

        if (abort) begin
            // Drop the current vector or pending result; o keeps its last value.
            state_d = ST_ACC;
            acc_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (hs) begin
                        if (last) begin
                            o_d     = sum;
                            acc_d   = '0;
                            idx_d   = '0;
                            state_d = ST_DONE;
                        end else begin
                            acc_d = sum;
                            idx_d = elem_idx + IW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_ACC;
                    end
                end
                default: state_d = ST_ACC;
            endcase
        end

        in_ready_d  = (state_d == ST_ACC);
        out_valid_d = (state_d == ST_DONE);
    end

    // State, datapath and handshake flags; in_ready stays low until after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_ACC;
            acc_q     <= '0;
            o         <= '0;
            elem_idx  <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            o         <= o_d;
            elem_idx  <= idx_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
        end
    end

endmodule
